// File: rtl/port_wr_sram_scanner_if.sv
// Status-beat bundle between the per-port SRAM scanner and the
// write-side matcher, with the scan controls and packed SRAM state.
interface port_wr_sram_scanner_if #(
    parameter int SRAM_NUM = 32,
    parameter int FREE_W   = 11,
    parameter int AMT_W    = 9
);
    logic                       scan_enable;
    logic                       match_suc;
    logic [SRAM_NUM-1:0]        occupy_mask;
    logic                       own_sram_valid;
    logic [4:0]                 own_sram;
    logic [SRAM_NUM*FREE_W-1:0] free_space_all;
    logic [SRAM_NUM*AMT_W-1:0]  packet_amount_all;
    logic [4:0]                 matching_sram;
    logic                       accessible;
    logic [FREE_W-1:0]          free_space;
    logic [AMT_W-1:0]           packet_amount;
    logic                       sweep_done;

    modport master (
        output scan_enable, match_suc, occupy_mask,
        output own_sram_valid, own_sram,
        output free_space_all, packet_amount_all,
        input  matching_sram, accessible,
        input  free_space, packet_amount, sweep_done
    );

    modport slave (
        input  scan_enable, match_suc, occupy_mask,
        input  own_sram_valid, own_sram,
        input  free_space_all, packet_amount_all,
        output matching_sram, accessible,
        output free_space, packet_amount, sweep_done
    );
endinterface

// File: rtl/port_wr_sram_scanner.sv
// Per-port rotating SRAM poller: presents one registered SRAM status
// beat per cycle to the write-side matcher and flags full sweeps.
module port_wr_sram_scanner #(
    parameter int SRAM_NUM = 32,
    parameter int PORT_ID  = 0,
    parameter int FREE_W   = 11,
    parameter int AMT_W    = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    port_wr_sram_scanner_if.slave bus
);
    localparam logic [4:0] PTR_RST  = 5'(PORT_ID % SRAM_NUM);
    localparam logic [4:0] PTR_LAST = 5'(SRAM_NUM - 1);
    localparam logic [5:0] CNT_LAST = 6'(SRAM_NUM - 1);

    logic [4:0]        r_ptr;
    logic [5:0]        r_cnt;
    logic [4:0]        r_idx;
    logic              r_acc;
    logic [FREE_W-1:0] r_free;
    logic [AMT_W-1:0]  r_amt;
    logic              r_done;

    logic              w_adv;
    logic [4:0]        w_ptr_nxt;
    logic [FREE_W-1:0] w_free_sel;
    logic [AMT_W-1:0]  w_amt_sel;
    logic              w_occ_sel;
    logic              w_own_hit;
    logic              w_acc_nxt;

    assign w_adv     = bus.scan_enable && !bus.match_suc;
    assign w_ptr_nxt = (r_ptr == PTR_LAST) ? 5'd0 : r_ptr + 5'd1;

    always_comb begin
        w_free_sel = '0;
        w_amt_sel  = '0;
        w_occ_sel  = 1'b0;
        for (int i = 0; i < SRAM_NUM; i++) begin
            if (r_ptr == 5'(i)) begin
                w_free_sel = bus.free_space_all[i*FREE_W +: FREE_W];
                w_amt_sel  = bus.packet_amount_all[i*AMT_W +: AMT_W];
                w_occ_sel  = bus.occupy_mask[i];
            end
        end
    end

    // r_ptr never reaches SRAM_NUM, so an out-of-range own_sram cannot hit
    assign w_own_hit = bus.own_sram_valid && (bus.own_sram == r_ptr);
    assign w_acc_nxt = bus.scan_enable && (!w_occ_sel || w_own_hit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= PTR_RST;
        end else if (w_adv) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_acc  <= 1'b0;
            r_free <= '0;
            r_amt  <= '0;
        end else begin
            r_idx  <= r_ptr;
            r_acc  <= w_acc_nxt;
            r_free <= w_free_sel;
            r_amt  <= w_amt_sel;
        end
    end

    // Sweep count restarts whenever the scan stops or a match lands
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (!w_adv) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_done <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 6'd1;
            r_done <= 1'b0;
        end
    end

    assign bus.matching_sram = r_idx;
    assign bus.accessible    = r_acc;
    assign bus.free_space    = r_free;
    assign bus.packet_amount = r_amt;
    assign bus.sweep_done    = r_done;
endmodule

// File: tb/tb_port_wr_sram_scanner.sv
// Directed bench for port_wr_sram_scanner with PORT_ID=3:
// vector table for sweeps, hand sequences for match/idle/reset cases.
module tb_port_wr_sram_scanner;
    localparam int N = 32;
    localparam int F = 11;
    localparam int A = 9;

    typedef struct {
        logic         rst;
        logic         scan;
        logic         suc;
        logic [N-1:0] mask;
        logic         ov;
        logic [4:0]   own;
        logic [4:0]   e_idx;
        logic         e_acc;
        logic         e_done;
        logic [F-1:0] e_fs;
        logic [A-1:0] e_amt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nfail = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    port_wr_sram_scanner_if #(.SRAM_NUM(N), .FREE_W(F), .AMT_W(A)) bus ();

    port_wr_sram_scanner #(
        .SRAM_NUM(N), .PORT_ID(3), .FREE_W(F), .AMT_W(A)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    function automatic logic [F-1:0] fsv(input int i);
        return (i == 7) ? F'(100) : F'(i * 13 + 5);
    endfunction

    function automatic logic [A-1:0] amv(input int i);
        return (i == 7) ? A'(42) : A'(i * 5 + 1);
    endfunction

    function automatic vec_t mk(input logic rst, input logic scan,
                                input logic suc, input logic [N-1:0] mask,
                                input logic ov, input logic [4:0] own,
                                input int idx, input logic acc,
                                input logic done);
        vec_t v;
        v.rst    = rst;
        v.scan   = scan;
        v.suc    = suc;
        v.mask   = mask;
        v.ov     = ov;
        v.own    = own;
        v.e_idx  = 5'(idx);
        v.e_acc  = acc;
        v.e_done = done;
        v.e_fs   = rst ? '0 : fsv(idx);
        v.e_amt  = rst ? '0 : amv(idx);
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        bus.scan_enable    = v.scan;
        bus.match_suc      = v.suc;
        bus.occupy_mask    = v.mask;
        bus.own_sram_valid = v.ov;
        bus.own_sram       = v.own;
        rst_n              = !v.rst;
        @(posedge clk);
        #1;
        nvec++;
        if (bus.matching_sram !== v.e_idx || bus.accessible !== v.e_acc ||
            bus.sweep_done !== v.e_done || bus.free_space !== v.e_fs ||
            bus.packet_amount !== v.e_amt) begin
            nfail++;
            $display("FAIL %s: got/want idx=%0d/%0d acc=%0b/%0b done=%0b/%0b fs=%0d/%0d amt=%0d/%0d",
                     tag, bus.matching_sram, v.e_idx, bus.accessible, v.e_acc,
                     bus.sweep_done, v.e_done, bus.free_space, v.e_fs,
                     bus.packet_amount, v.e_amt);
        end
    endtask

    task automatic step(input logic rst, input logic scan, input logic suc,
                        input int idx, input logic acc, input logic done,
                        input string tag);
        apply(mk(rst, scan, suc, '0, 1'b0, 5'd0, idx, acc, done), tag);
    endtask

    initial begin
        logic [N-1:0] m5;
        logic [N-1:0] m59;
        m5  = '0;
        m5[5] = 1'b1;
        m59 = m5;
        m59[9] = 1'b1;

        for (int i = 0; i < N; i++) begin
            bus.free_space_all[i*F +: F]    = fsv(i);
            bus.packet_amount_all[i*A +: A] = amv(i);
        end
        bus.scan_enable    = 1'b0;
        bus.match_suc      = 1'b0;
        bus.occupy_mask    = '0;
        bus.own_sram_valid = 1'b0;
        bus.own_sram       = '0;

        // reset, then three full sweeps starting at SRAM 3
        tbl.push_back(mk(1, 0, 0, '0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, '0, 0, 0, 0, 0, 0));
        for (int k = 0; k < N; k++)
            tbl.push_back(mk(0, 1, 0, '0, 0, 0, (3 + k) % N, 1, k == N - 1));
        for (int k = 0; k < N; k++)
            tbl.push_back(mk(0, 1, 0, m5, 0, 0, (3 + k) % N,
                             ((3 + k) % N) != 5, k == N - 1));
        for (int k = 0; k < N; k++)
            tbl.push_back(mk(0, 1, 0, m59, 1, 5, (3 + k) % N,
                             ((3 + k) % N) != 9, k == N - 1));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // match_suc at ptr=10 freezes the pointer and restarts the sweep
        for (int k = 3; k < 10; k++) step(0, 1, 0, k, 1, 0, "pre_suc");
        step(0, 1, 1, 10, 1, 0, "suc_beat");
        for (int j = 1; j <= N; j++)
            step(0, 1, 0, (10 + j - 1) % N, 1, j == N, "post_suc");

        // idle for 5 cycles at ptr=20, then resume from 20
        for (int k = 10; k < 20; k++) step(0, 1, 0, k, 1, 0, "pre_idle");
        for (int j = 0; j < 5; j++) step(0, 0, 0, 20, 0, 0, "idle");
        for (int j = 1; j <= N; j++)
            step(0, 1, 0, (20 + j - 1) % N, 1, j == N, "resume");

        // one-cycle reset mid-scan
        for (int k = 20; k < 23; k++) step(0, 1, 0, k, 1, 0, "pre_rst");
        step(1, 1, 0, 0, 0, 0, "mid_rst");
        step(0, 1, 0, 3, 1, 0, "post_rst0");
        step(0, 1, 0, 4, 1, 0, "post_rst1");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
